// File: rtl/vga_timing_pkg.sv
// Shared timing constants, mode presets and total-length helpers for the VGA timing generator.
package vga_timing_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
        bit          pol;
    } axis_timing_t;

    localparam axis_timing_t SVGA_800X600_60_H = '{800, 40, 128, 88, 1'b1};
    localparam axis_timing_t SVGA_800X600_60_V = '{600, 1, 4, 23, 1'b1};
    localparam axis_timing_t VGA_640X480_60_H  = '{640, 16, 96, 48, 1'b0};
    localparam axis_timing_t VGA_640X480_60_V  = '{480, 10, 2, 33, 1'b0};

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 40;
    localparam int DEF_H_SYNC   = 128;
    localparam int DEF_H_BP     = 88;
    localparam int DEF_V_ACTIVE = 600;
    localparam int DEF_V_FP     = 1;
    localparam int DEF_V_SYNC   = 4;
    localparam int DEF_V_BP     = 23;
    localparam int DEF_H_POL    = 1;
    localparam int DEF_V_POL    = 1;
    localparam int DEF_CW       = 11;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return axis_total(active, fp, sync, bp);
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return axis_total(active, fp, sync, bp);
    endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One timing axis: position counter with wrap/restart, plus active and sync window decode.
module vga_axis_cnt
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter int CW     = DEF_CW
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          step,
    input  logic          restart,
    output logic [CW-1:0] cnt,
    output logic          last,
    output logic          in_active,
    output logic          in_sync
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [CW-1:0] LAST_POS   = CW'(TOTAL - 1);
    localparam logic [CW-1:0] ACTIVE_END = CW'(ACTIVE);
    localparam logic [CW-1:0] SYNC_BEG   = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] SYNC_END   = CW'(ACTIVE + FP + SYNC);

    logic [CW-1:0] cnt_q, cnt_d;

    // Restart wins over a normal step so a resync lands exactly on position 0.
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (step) begin
            cnt_d = (cnt_q == LAST_POS) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt       = cnt_q;
    assign last      = (cnt_q == LAST_POS);
    assign in_active = (cnt_q < ACTIVE_END);
    assign in_sync   = (cnt_q >= SYNC_BEG) && (cnt_q < SYNC_END);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync/pixel timing generator with registered outputs one enabled cycle behind the counters.
// Frame counter present only when VGA_TIMING_FRAMECNT_EN is defined; otherwise frame_cnt is tied to 0.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int H_POL    = DEF_H_POL,
    parameter int V_POL    = DEF_V_POL,
    parameter int CW       = DEF_CW
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          pix_en,
    input  logic          resync,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic [CW-1:0] pixh,
    output logic [CW-1:0] pixv,
    output logic          line_start,
    output logic          frame_start,
    output logic [15:0]   frame_cnt
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam logic H_ON = (H_POL != 0);
    localparam logic V_ON = (V_POL != 0);

    if (CW > 30 || H_TOTAL >= (1 << CW)) begin : g_h_total_check
        $fatal(1, "H_TOTAL does not fit in CW bits");
    end
    if (CW > 30 || V_TOTAL >= (1 << CW)) begin : g_v_total_check
        $fatal(1, "V_TOTAL does not fit in CW bits");
    end

    logic [CW-1:0] h_cnt, v_cnt;
    logic          h_last, v_last, h_in_active, v_in_active, h_in_sync, v_in_sync;
    logic          resync_eff, restart, v_step;

    logic          resync_pend_q, resync_pend_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d, active_q, active_d;
    logic [CW-1:0] pixh_q, pixh_d, pixv_q, pixv_d;
    logic          line_start_q, line_start_d, frame_start_q, frame_start_d;

    assign resync_eff = resync | resync_pend_q;
    assign restart    = pix_en & resync_eff;
    assign v_step     = pix_en & h_last;

    vga_axis_cnt #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)
    ) u_h_axis (
        .clk(clk), .clr(clr), .step(pix_en), .restart(restart),
        .cnt(h_cnt), .last(h_last), .in_active(h_in_active), .in_sync(h_in_sync)
    );

    vga_axis_cnt #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)
    ) u_v_axis (
        .clk(clk), .clr(clr), .step(v_step), .restart(restart),
        .cnt(v_cnt), .last(v_last), .in_active(v_in_active), .in_sync(v_in_sync)
    );

    // Outputs decode the pre-edge counters; pulses fall on any disabled edge, everything else holds.
    always_comb begin
        resync_pend_d = pix_en ? 1'b0 : resync_eff;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        active_d      = active_q;
        pixh_d        = pixh_q;
        pixv_d        = pixv_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (pix_en) begin
            hsync_d       = h_in_sync ? H_ON : ~H_ON;
            vsync_d       = v_in_sync ? V_ON : ~V_ON;
            active_d      = h_in_active & v_in_active;
            line_start_d  = (h_cnt == '0);
            frame_start_d = (h_cnt == '0) && (v_cnt == '0);
            if (h_in_active && v_in_active) begin
                pixh_d = h_cnt;
                pixv_d = v_cnt;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            resync_pend_q <= 1'b0;
            hsync_q       <= ~H_ON;
            vsync_q       <= ~V_ON;
            active_q      <= 1'b0;
            pixh_q        <= '0;
            pixv_q        <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            resync_pend_q <= resync_pend_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            pixh_q        <= pixh_d;
            pixv_q        <= pixv_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign active      = active_q;
    assign pixh        = pixh_q;
    assign pixv        = pixv_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAMECNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // A resync is a restart, not a completed frame, so it never counts.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (pix_en && !resync_eff && h_last && v_last) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    logic unused_v_last;
    assign unused_v_last = v_last;
    assign frame_cnt     = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a 16x8 toy timing; frame_cnt expectations follow VGA_TIMING_FRAMECNT_EN.
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int CW = 11;

    logic          clk = 1'b0;
    logic          clr;
    logic          pix_en;
    logic          resync;
    logic          hsync, vsync, active, line_start, frame_start;
    logic [CW-1:0] pixh, pixv;
    logic [15:0]   frame_cnt;

    int pass_count = 0;
    int check_count = 0;
    bit cmp_en = 1'b0;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1), .V_POL(1), .CW(CW)
    ) dut (
        .clk(clk), .clr(clr), .pix_en(pix_en), .resync(resync),
        .hsync(hsync), .vsync(vsync), .active(active),
        .pixh(pixh), .pixv(pixv),
        .line_start(line_start), .frame_start(frame_start),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural model: the raster is a linear pixel index 0..FRAME-1.
    int m_p = 0;
    bit m_pend = 1'b0;
    int m_h, m_v;
    int e_hs = 0, e_vs = 0, e_act = 0, e_ph = 0, e_pv = 0, e_ls = 0, e_fs = 0, e_fc = 0;

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_p = 0; m_pend = 1'b0;
            e_hs = 0; e_vs = 0; e_act = 0; e_ph = 0; e_pv = 0;
            e_ls = 0; e_fs = 0; e_fc = 0;
        end else if (pix_en) begin
            m_h = m_p % HT;
            m_v = m_p / HT;
            e_act = (m_h < HA && m_v < VA) ? 1 : 0;
            if (e_act == 1) begin
                e_ph = m_h;
                e_pv = m_v;
            end
            e_hs = (m_h >= HA + HF && m_h < HA + HF + HS) ? 1 : 0;
            e_vs = (m_v >= VA + VF && m_v < VA + VF + VS) ? 1 : 0;
            e_ls = (m_h == 0) ? 1 : 0;
            e_fs = (m_p == 0) ? 1 : 0;
            if (resync || m_pend) begin
                m_p = 0;
                m_pend = 1'b0;
            end else begin
                if (m_p == FRAME - 1) e_fc = (e_fc + 1) % 65536;
                m_p = (m_p + 1) % FRAME;
            end
        end else begin
            e_ls = 0;
            e_fs = 0;
            m_pend = m_pend | resync;
        end
    end

    function automatic int exp_fc(input int n);
`ifdef VGA_TIMING_FRAMECNT_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        check_count++;
        if (actual == expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s actual=%0d expected=%0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic rs);
        pix_en = en;
        resync = rs;
        @(posedge clk);
        #1;
    endtask

    // Every-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("cyc_hsync", int'(hsync), e_hs);
            checkOutput("cyc_vsync", int'(vsync), e_vs);
            checkOutput("cyc_active", int'(active), e_act);
            checkOutput("cyc_pixh", int'(pixh), e_ph);
            checkOutput("cyc_pixv", int'(pixv), e_pv);
            checkOutput("cyc_line_start", int'(line_start), e_ls);
            checkOutput("cyc_frame_start", int'(frame_start), e_fs);
            checkOutput("cyc_frame_cnt", int'(frame_cnt), exp_fc(e_fc));
        end
    end

    logic [15:0] act_hist, hs_hist, ls_hist;
    int fs_count, fs_first, fs_second, vs_count, act_count, ls_count, guard;

    initial begin
        clr = 1'b1;
        pix_en = 1'b1;
        resync = 1'b0;
        repeat (3) applyStimulus(1'b1, 1'b0);
        cmp_en = 1'b1;
        checkOutput("rst_hsync", int'(hsync), 0);
        checkOutput("rst_vsync", int'(vsync), 0);
        checkOutput("rst_active", int'(active), 0);
        checkOutput("rst_frame_start", int'(frame_start), 0);
        checkOutput("rst_frame_cnt", int'(frame_cnt), 0);

        // Two full frames from reset release
        clr = 1'b0;
        act_hist = '0; hs_hist = '0; ls_hist = '0;
        fs_count = 0; fs_first = -1; fs_second = -1; vs_count = 0;
        for (int k = 1; k <= 2 * FRAME; k++) begin
            applyStimulus(1'b1, 1'b0);
            if (k <= 16) begin
                act_hist[k-1] = active;
                hs_hist[k-1]  = hsync;
                ls_hist[k-1]  = line_start;
            end
            if (frame_start) begin
                fs_count++;
                if (fs_first < 0) fs_first = k;
                else if (fs_second < 0) fs_second = k;
            end
            if (vsync) vs_count++;
        end
        checkOutput("line0_active", int'(act_hist), 16'h00FF);
        checkOutput("line0_hsync", int'(hs_hist), 16'h1C00);
        checkOutput("line0_line_start", int'(ls_hist), 16'h0001);
        checkOutput("frames_fs_count", fs_count, 2);
        checkOutput("frames_fs_first", fs_first, 1);
        checkOutput("frames_fs_second", fs_second, 129);
        checkOutput("frames_vsync_clks", vs_count, 64);
        checkOutput("frames_frame_cnt", int'(frame_cnt), exp_fc(2));

        // pix_en alternating 1,0 over one line
        act_count = 0; ls_count = 0;
        for (int k = 0; k < 32; k++) begin
            applyStimulus((k % 2) == 0, 1'b0);
            if (active) act_count++;
            if (line_start) ls_count++;
            if (k == 1) checkOutput("stretch_ls_drop", int'(line_start), 0);
        end
        checkOutput("stretch_active_clks", act_count, 16);
        checkOutput("stretch_ls_clks", ls_count, 1);

        // Resync at (5,2)
        guard = 0;
        while (m_p != 2 * HT + 5 && guard < 2 * FRAME) begin
            applyStimulus(1'b1, 1'b0);
            guard++;
        end
        checkOutput("resync_reach_pos", guard < 2 * FRAME ? 1 : 0, 1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("resync_old_pixh", int'(pixh), 5);
        checkOutput("resync_old_pixv", int'(pixv), 2);
        checkOutput("resync_old_fs", int'(frame_start), 0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("resync_fs", int'(frame_start), 1);
        checkOutput("resync_frame_cnt", int'(frame_cnt), exp_fc(2));

        // Resync requested while disabled is applied at the next enabled edge
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("pend_old_fs", int'(frame_start), 0);
        checkOutput("pend_old_pixh", int'(pixh), 3);
        applyStimulus(1'b1, 1'b0);
        checkOutput("pend_fs", int'(frame_start), 1);

        // Asynchronous clear mid-line
        repeat (3) applyStimulus(1'b1, 1'b0);
        #2;
        clr = 1'b1;
        #1;
        checkOutput("aclr_hsync", int'(hsync), 0);
        checkOutput("aclr_active", int'(active), 0);
        checkOutput("aclr_pixh", int'(pixh), 0);
        checkOutput("aclr_line_start", int'(line_start), 0);
        checkOutput("aclr_frame_cnt", int'(frame_cnt), 0);
        @(posedge clk);
        #3;
        clr = 1'b0;
        fs_count = 0; vs_count = 0;
        applyStimulus(1'b1, 1'b0);
        checkOutput("aclr_first_fs", int'(frame_start), 1);
        checkOutput("aclr_first_ls", int'(line_start), 1);
        if (frame_start) fs_count++;
        if (vsync) vs_count++;

        // Three frames from the release
        for (int k = 2; k <= 3 * FRAME; k++) begin
            applyStimulus(1'b1, 1'b0);
            if (frame_start) fs_count++;
            if (vsync) vs_count++;
        end
        checkOutput("three_fs_count", fs_count, 3);
        checkOutput("three_vsync_clks", vs_count, 96);
        checkOutput("three_frame_cnt", int'(frame_cnt), exp_fc(3));

        @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
  H_ACTIVE, 800, visible pixels per line
  H_FP, 40, horizontal front porch (pixels)
  H_SYNC, 128, horizontal sync width
  H_BP, 88, horizontal back porch
  V_ACTIVE, 600, visible lines per frame
  V_FP, 1, vertical front porch (lines)
  V_SYNC, 4, vertical sync width
  V_BP, 23, vertical back porch
  H_POL, 1, hsync asserted level (1 = active-high)
  V_POL, 1, vsync asserted level
  CW, 11, counter and coordinate width
REQ-002 Ports SHALL be, as name, direction, width, meaning:
  clk  in  1  system clock; one clock, all logic on rising edge
  clr  in  1  reset, asynchronous, active-high
  pix_en  in  1  pixel-rate enable; counters and outputs advance only when 1
  resync  in  1  synchronous request to restart the frame at (0,0)
  hsync  out  1  horizontal sync
  vsync  out  1  vertical sync
  active  out  1  current pixel is visible
  pixh  out  CW  horizontal coordinate of the visible pixel
  pixv  out  CW  vertical coordinate of the visible pixel
  line_start  out  1  one-clk pulse, first pixel of any line
  frame_start  out  1  one-clk pulse, pixel (0,0)
  frame_cnt  out  16  frames completed

Function
REQ-003 Line order SHALL be active, front porch, sync, back porch; H_TOTAL = sum of H params and V_TOTAL = sum of V params, both held as package-style localparams.
REQ-004 hcnt SHALL run 0..H_TOTAL-1 and wrap to 0; vcnt SHALL increment only on hcnt wrap and run 0..V_TOTAL-1, then wrap to 0.
REQ-005 Counters and all outputs SHALL update only on clk edges with pix_en=1. With pix_en=0, everything holds, except that line_start and frame_start drop to 0.
REQ-006 On an enabled edge, outputs SHALL be computed from the pre-edge counter values, giving a latency of exactly one enabled cycle from counter position to output.
REQ-007 active SHALL be (hcnt<H_ACTIVE && vcnt<V_ACTIVE).
REQ-008 When active, pixh SHALL equal hcnt and pixv SHALL equal vcnt; when not active, pixh and pixv SHALL hold their last values.
REQ-009 hsync SHALL be at level H_POL when H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC, and at !H_POL otherwise.
REQ-010 vsync SHALL follow the same rule on vcnt using the V params and V_POL, independent of hcnt.
REQ-011 line_start SHALL pulse when hcnt==0; frame_start SHALL pulse when hcnt==0 && vcnt==0. Both are one clk wide.
REQ-012 On resync=1 with pix_en=1, both counters SHALL load 0 and outputs SHALL reflect the pre-edge counters. With pix_en=0, resync SHALL be latched as pending and applied at the next enabled edge.
REQ-013 On wrap from (H_TOTAL-1, V_TOTAL-1), frame_cnt SHALL increment modulo 2^16. A resync SHALL NOT increment frame_cnt.
REQ-014 Elaboration SHALL fail if H_TOTAL or V_TOTAL >= 2^CW.

Reset
REQ-015 While clr=1, regardless of clk or pix_en: hcnt=0, vcnt=0, hsync=!H_POL, vsync=!V_POL, active=0, pixh=0, pixv=0, line_start=0, frame_start=0, frame_cnt=0, pending resync cleared.
REQ-016 After clr deasserts mid-frame, the first enabled edge SHALL produce frame_start=1 and line_start=1.

Configuration
REQ-017 With VGA_TIMING_FRAMECNT_EN defined, frame_cnt SHALL behave per REQ-013.
REQ-018 Without VGA_TIMING_FRAMECNT_EN, the frame_cnt port SHALL still exist, be constant 0, and use no counter flops.

Structure
REQ-019 Package vga_timing_pkg SHALL hold the default timing constants, the H_TOTAL/V_TOTAL helper functions, and the 800x600@60 and 640x480@60 preset constants.
REQ-020 One sub-module, vga_axis_cnt, SHALL implement one axis (count, wrap, sync window, active window) and be instantiated once per axis.

Verification
Small bench parameters: H=8/2/3/3 (total 16), V=4/1/2/1 (total 8), pols 1, pix_en=1 unless stated.
REQ-021 Reset release, run 16 clks: active=1 on outputs 1..8, hsync=1 on outputs 11..13, line_start on output 1 only.
REQ-022 Run 2 full frames (256 clks): frame_start every 128 clks, vsync=1 for lines 5..6 (32 clks), frame_cnt=2.
REQ-023 pix_en toggling 1,0,1,0: output sequence equals the pix_en=1 sequence stretched x2, with pulses exactly one clk wide.
REQ-024 resync at hcnt=5, vcnt=2: the next output shows old position (5,2), then frame_start; frame_cnt is unchanged.
REQ-025 clr asserted asynchronously mid-line: all outputs reach reset values before the next clk edge; first enabled edge after release gives frame_start=1.
REQ-026 Build without VGA_TIMING_FRAMECNT_EN, run 3 frames: frame_cnt stays 0 and all other outputs match REQ-022.
